// File: rtl/phase_sched_pkg.sv
// Shared types and constants for the phase scheduler and its dwell timer.
package phase_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DRAIN} state_e;

  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = 2;

  localparam logic [1:0] COND_HOLD = 2'b00;
  localparam logic [1:0] COND_ADV  = 2'b01;
endpackage

// File: rtl/phase_scheduler_dwell_timer.sv
// Down-counting dwell timer: load wins over decrement, done flags the final cycle of a phase.
module dwell_timer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  output logic          done
);
  logic [DW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - DW'(1);
    end
  end

  assign done = (count == DW'(1));
endmodule

// File: rtl/phase_scheduler.sv
// Phase scheduler: dwells in each stepper phase, then pulses an advance on cond_o.
// Optional lock-step check against the stepper's state is enabled by PHASE_CHECK_EN.
module phase_scheduler
  import phase_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LAP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [4*DW-1:0]    dwell_cfg,
`ifdef PHASE_CHECK_EN
  input  logic [1:0]         stepper_state,
  output logic               sync_err,
`endif
  output logic [1:0]         cond_o,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               lap_done,
  output logic [LAP_W-1:0]   lap_count,
  output state_e             state_dbg
);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_e            state;
  logic              timer_done;
  logic              advance;
  logic              timer_load;
  logic              timer_dec;
  logic [DW-1:0]     timer_val;
  logic [PHASE_W-1:0] next_phase;

  // A zero dwell setting still holds the phase for one cycle.
  function automatic logic [DW-1:0] eff_dwell(input logic [PHASE_W-1:0] p);
    logic [DW-1:0] v;
    v = dwell_cfg[int'(p)*DW +: DW];
    return (v == '0) ? DW'(1) : v;
  endfunction

  assign advance    = ((state == RUN) || (state == DRAIN)) && timer_done;
  assign next_phase = phase + PHASE_W'(1);
  assign timer_load = ((state == IDLE) && start) || advance;
  assign timer_val  = (state == IDLE) ? eff_dwell('0) : eff_dwell(next_phase);
  assign timer_dec  = ((state == RUN) || (state == DRAIN)) && !advance;

  dwell_timer #(.DW(DW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  assign cond_o    = advance ? COND_ADV : COND_HOLD;
  assign lap_done  = advance && (phase == LAST_PHASE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
`ifdef PHASE_CHECK_EN
      sync_err <= 1'b0;
`endif
    end
`ifdef PHASE_CHECK_EN
    else if ((state != IDLE) && (stepper_state != phase)) begin
      sync_err <= 1'b1;
      state    <= IDLE;
      phase    <= '0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            phase <= '0;
          end
        end
        RUN: begin
          if (advance) phase <= next_phase;
          if (stop)       state <= DRAIN;
          else if (pause) state <= PAUSED;
        end
        PAUSED: begin
          if (stop)        state <= DRAIN;
          else if (!pause) state <= RUN;
        end
        DRAIN: begin
          if (advance) begin
            phase <= next_phase;
            if (phase == LAST_PHASE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-lap counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_count <= '0;
    end else if (lap_done && (lap_count != '1)) begin
      lap_count <= lap_count + LAP_W'(1);
    end
  end
endmodule
